// File: rtl/simple_bus_master.sv
// Initiator for the single-channel "simple" memory bus: one outstanding load/store,
// fixed read latency, sized/extended load data. Optional define: MISALIGN_CHECK_EN.
module simple_bus_master #(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [2:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        simple_out_valid,
    input  logic        simple_out_ready,
    output logic [31:0] simple_out_bits_addr,
    output logic        simple_out_bits_writeEn,
    output logic [2:0]  simple_out_bits_size,
    output logic [31:0] simple_out_bits_wdata,
    input  logic [31:0] simple_in_rdata,
    output logic [1:0]  dbg_state_o
);

    // One counter serves both the ISSUE timeout and the WAIT latency countdown.
    localparam int MAXV = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
    localparam int CW   = (MAXV < 1) ? 1 : $clog2(MAXV + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [2:0]    size_q;
    logic          wen_q;
    logic          uns_q;
    logic          err_q;

    logic          req_fire;
    logic          bus_fire;
    logic          resp_fire;
    logic          timeout_d;
    logic          misalign_d;
    logic [31:0]   rdata_d;

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [2:0] sz,
                                            input logic uns);
        logic [31:0] r;
        case (sz)
            3'd0:    r = uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            3'd1:    r = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [1:0] a, input logic [2:0] sz);
        logic m;
        case (sz)
            3'd0:    m = 1'b0;
            3'd1:    m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction
`endif

    always_comb begin
        req_fire  = (state_q == IDLE) && req_valid;
        bus_fire  = (state_q == ISSUE) && simple_out_ready;
        resp_fire = (state_q == RESP) && resp_ready;
        rdata_d   = extract(simple_in_rdata, size_q, uns_q);
        timeout_d = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
`ifdef MISALIGN_CHECK_EN
        misalign_d = is_misaligned(req_addr[1:0], req_size);
`else
        misalign_d = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= req_size;
                        wen_q   <= req_wen;
                        uns_q   <= req_unsigned;
                        cnt_q   <= '0;
                        if (misalign_d) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus_fire) begin
                        if (wen_q) begin
                            rdata_q <= '0;
                            err_q   <= 1'b0;
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CW'(RD_LAT - 1);
                            state_q <= WAIT;
                        end
                    end else if (timeout_d) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    // The edge seeing zero is request-accept edge + RD_LAT.
                    if (cnt_q == '0) begin
                        rdata_q <= rdata_d;
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_fire) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready               = (state_q == IDLE);
    assign simple_out_valid        = (state_q == ISSUE);
    assign resp_valid              = (state_q == RESP);
    assign resp_rdata              = rdata_q;
    assign resp_err                = err_q;
    assign simple_out_bits_addr    = addr_q;
    assign simple_out_bits_writeEn = wen_q;
    assign simple_out_bits_size    = size_q;
    assign simple_out_bits_wdata   = wdata_q;
    assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_simple_bus_master.sv
// Directed bench for simple_bus_master (RD_LAT=2, TIMEOUT=4) with a fixed-latency responder.
module tb_simple_bus_master;

    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        simple_out_valid;
    logic        simple_out_ready;
    logic [31:0] simple_out_bits_addr;
    logic        simple_out_bits_writeEn;
    logic [2:0]  simple_out_bits_size;
    logic [31:0] simple_out_bits_wdata;
    logic [31:0] simple_in_rdata = 32'hBAD0BAD0;
    logic [1:0]  dbg_state_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] bus_rdata = 32'h0;
    int          pend = 0;

    always #5 clock = ~clock;

    simple_bus_master #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .simple_out_valid(simple_out_valid), .simple_out_ready(simple_out_ready),
        .simple_out_bits_addr(simple_out_bits_addr),
        .simple_out_bits_writeEn(simple_out_bits_writeEn),
        .simple_out_bits_size(simple_out_bits_size),
        .simple_out_bits_wdata(simple_out_bits_wdata),
        .simple_in_rdata(simple_in_rdata), .dbg_state_o(dbg_state_o)
    );

    // Responder: read data is valid only for the edge at accept + RD_LAT.
    always @(posedge clock) begin
        if (simple_out_valid && simple_out_ready && !simple_out_bits_writeEn) pend = RD_LAT;
        else if (pend > 0) pend = pend - 1;
        #1 simple_in_rdata = (pend == 1) ? bus_rdata : 32'hBAD0BAD0;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_req(input logic [31:0] a, input logic w, input logic [2:0] s,
                             input logic u, input logic [31:0] d);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_size = s; req_unsigned = u; req_wdata = d;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_idle got %b exp 1", req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL release got resp_valid %b req_ready %b exp 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0; simple_out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || simple_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs got rr %b rv %b ov %b exp 1 0 0", req_ready, resp_valid, simple_out_valid);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_resp got %h %b exp 0 0", resp_rdata, resp_err);
        end
        checks++;
        if (simple_out_bits_addr !== 32'h0 || simple_out_bits_wdata !== 32'h0 ||
            simple_out_bits_size !== 3'h0 || simple_out_bits_writeEn !== 1'b0) begin
            errors++; $display("FAIL reset_bus got addr %h wdata %h exp 0 0", simple_out_bits_addr, simple_out_bits_wdata);
        end
        checks++;
        if (dbg_state_o !== 2'd0) begin
            errors++; $display("FAIL reset_state got %0d exp 0", dbg_state_o);
        end
    endtask

    task automatic test_store();
        simple_out_ready = 1'b1;
        issue_req(32'h80000003, 1'b1, 3'd0, 1'b0, 32'h000000A5);
        checks++;
        if (simple_out_valid !== 1'b1 || simple_out_bits_addr !== 32'h80000003 ||
            simple_out_bits_writeEn !== 1'b1 || simple_out_bits_size !== 3'd0 ||
            simple_out_bits_wdata !== 32'h000000A5 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL store_bus got v %b addr %h we %b sz %0d wd %h rv %b exp 1 80000003 1 0 000000a5 0",
                               simple_out_valid, simple_out_bits_addr, simple_out_bits_writeEn,
                               simple_out_bits_size, simple_out_bits_wdata, resp_valid);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || simple_out_valid !== 1'b0) begin
            errors++; $display("FAIL store_resp got rv %b rd %h err %b ov %b exp 1 0 0 0",
                               resp_valid, resp_rdata, resp_err, simple_out_valid);
        end
        release_resp();
    endtask

    task automatic test_load(input logic [31:0] a, input logic [2:0] s, input logic u,
                             input logic [31:0] bus, input logic [31:0] exp);
        simple_out_ready = 1'b1;
        bus_rdata = bus;
        issue_req(a, 1'b0, s, u, 32'h0);
        for (int i = 1; i <= RD_LAT + 2; i++) begin
            if (i > 1) step();
            checks++;
            if (resp_valid !== (i == RD_LAT + 2)) begin
                errors++; $display("FAIL load_latency cycle %0d got rv %b exp %b", i, resp_valid, (i == RD_LAT + 2));
            end
        end
        checks++;
        if (resp_rdata !== exp || resp_err !== 1'b0) begin
            errors++; $display("FAIL load_data addr %h size %0d uns %b got %h err %b exp %h 0",
                               a, s, u, resp_rdata, resp_err, exp);
        end
        release_resp();
    endtask

    task automatic test_timeout();
        simple_out_ready = 1'b0;
        bus_rdata = 32'h55555555;
        issue_req(32'h00000200, 1'b0, 3'd2, 1'b0, 32'h0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            checks++;
            if (simple_out_valid !== 1'b1 || resp_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_wait cycle %0d got ov %b rv %b exp 1 0", i, simple_out_valid, resp_valid);
            end
            step();
        end
        checks++;
        if (simple_out_valid !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL timeout_resp got ov %b rv %b err %b rd %h exp 0 1 1 0",
                               simple_out_valid, resp_valid, resp_err, resp_rdata);
        end
        release_resp();
        simple_out_ready = 1'b1;
    endtask

    task automatic test_resp_hold();
        simple_out_ready = 1'b1;
        bus_rdata = 32'h000000FF;
        issue_req(32'h00000010, 1'b0, 3'd0, 1'b0, 32'h0);
        step(); step(); step();
        req_valid = 1'b1; req_addr = 32'h40; req_wen = 1'b1; req_size = 3'd2; req_wdata = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFFFF || resp_err !== 1'b0 ||
                req_ready !== 1'b0 || simple_out_valid !== 1'b0) begin
                errors++; $display("FAIL resp_hold cycle %0d got rv %b rd %h err %b rr %b ov %b exp 1 ffffffff 0 0 0",
                                   i, resp_valid, resp_rdata, resp_err, req_ready, simple_out_valid);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || simple_out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release got rv %b rr %b ov %b exp 0 1 0", resp_valid, req_ready, simple_out_valid);
        end
        step();
        req_valid = 1'b0;
        checks++;
        if (simple_out_valid !== 1'b1 || simple_out_bits_addr !== 32'h40 || req_ready !== 1'b0) begin
            errors++; $display("FAIL next_accept got ov %b addr %h rr %b exp 1 00000040 0",
                               simple_out_valid, simple_out_bits_addr, req_ready);
        end
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++; $display("FAIL next_store_resp got rv %b rd %h err %b exp 1 0 0", resp_valid, resp_rdata, resp_err);
        end
        release_resp();
    endtask

    task automatic test_reset_mid();
        simple_out_ready = 1'b1;
        bus_rdata = 32'h00001234;
        issue_req(32'h00000300, 1'b0, 3'd2, 1'b0, 32'h0);
        step();
        checks++;
        if (dbg_state_o !== 2'd2) begin
            errors++; $display("FAIL mid_in_wait got state %0d exp 2", dbg_state_o);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || simple_out_valid !== 1'b0) begin
                errors++; $display("FAIL mid_reset cycle %0d got rv %b rr %b ov %b exp 0 1 0",
                                   i, resp_valid, req_ready, simple_out_valid);
            end
            step();
        end
    endtask

    task automatic test_misalign();
        simple_out_ready = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        issue_req(32'h00000102, 1'b0, 3'd2, 1'b0, 32'h0);
`ifdef MISALIGN_CHECK_EN
        checks++;
        if (simple_out_valid !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            errors++; $display("FAIL misalign_err got ov %b rv %b err %b rd %h exp 0 1 1 0",
                               simple_out_valid, resp_valid, resp_err, resp_rdata);
        end
`else
        checks++;
        if (simple_out_valid !== 1'b1 || simple_out_bits_addr !== 32'h00000102) begin
            errors++; $display("FAIL misalign_issue got ov %b addr %h exp 1 00000102", simple_out_valid, simple_out_bits_addr);
        end
        step(); step(); step();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL misalign_data got rv %b err %b rd %h exp 1 0 cafef00d", resp_valid, resp_err, resp_rdata);
        end
`endif
        release_resp();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load(32'h00000000, 3'd0, 1'b0, 32'h12345680, 32'hFFFFFF80);
        test_load(32'h00000000, 3'd0, 1'b1, 32'h12345680, 32'h00000080);
        test_load(32'h00000004, 3'd0, 1'b0, 32'h1234567F, 32'h0000007F);
        test_load(32'h00000100, 3'd1, 1'b1, 32'hDEAD8001, 32'h00008001);
        test_load(32'h00000100, 3'd1, 1'b0, 32'hDEAD8001, 32'hFFFF8001);
        test_load(32'h00000100, 3'd2, 1'b1, 32'hDEAD8001, 32'hDEAD8001);
        test_load(32'h00000100, 3'd5, 1'b1, 32'h9EAD8081, 32'h9EAD8081);
        test_timeout();
        test_resp_hold();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
